conv_mac_int4_int16: RTL



---
 rtl/conv_mac_int4_int16.sv | 97 +++++++++
 1 files changed

// File: rtl/conv_mac_int4_int16.sv
// rtl/conv_mac_int4_int16.sv - int4 x int4 multiply-accumulate over ACC_LEN beats plus int16 bias.
// Define CONV_MAC_ACC_SAT_EN for per-step int16 saturating accumulation (default wraps).
module conv_mac_int4_int16 #(
  parameter int ACC_LEN = 9,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  data_in,
  input  logic [3:0]  weight_in,
  input  logic [15:0] bias_in,
  input  logic        flush,
  output logic [15:0] acc_out,
  output logic        out_valid,
  output logic        busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;
  localparam logic [CNT_W:0] LP_ACC_LEN = (CNT_W+1)'(ACC_LEN);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_acc;
  logic [15:0]      r_acc_out;
  logic             r_out_valid;

  logic [7:0]       w_data_ext;
  logic [7:0]       w_weight_ext;
  logic [7:0]       w_prod;
  logic [15:0]      w_prod16;
  logic [15:0]      w_base;
  logic [15:0]      w_sum;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_beat;
  logic             w_last;

  // The low 8 bits of the sign-extended product are exact: |a*b| <= 64 fits int8.
  assign w_data_ext   = {{4{data_in[3]}}, data_in};
  assign w_weight_ext = {{4{weight_in[3]}}, weight_in};
  assign w_prod       = w_data_ext * w_weight_ext;
  assign w_prod16     = {{8{w_prod[7]}}, w_prod};

  assign w_base = (r_state == S_IDLE) ? bias_in : r_acc;

`ifdef CONV_MAC_ACC_SAT_EN
  logic [16:0] w_sum17;
  assign w_sum17 = {w_base[15], w_base} + {w_prod16[15], w_prod16};
  always_comb begin
    w_sum = w_sum17[15:0];
    if (w_sum17[16] != w_sum17[15]) begin
      w_sum = w_sum17[16] ? 16'h8000 : 16'h7FFF;
    end
  end
`else
  assign w_sum = w_base + w_prod16;
`endif

  assign w_beat    = in_valid && !flush;
  assign w_cnt_inc = (r_state == S_IDLE) ? {{CNT_W{1'b0}}, 1'b1} : ({1'b0, r_cnt} + 1'b1);
  assign w_last    = w_beat && (w_cnt_inc == LP_ACC_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (w_beat) begin
        if (w_last) begin
          r_acc_out   <= w_sum;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_acc       <= '0;
        end else begin
          r_acc   <= w_sum;
          r_cnt   <= w_cnt_inc[CNT_W-1:0];
          r_state <= S_ACC;
        end
      end
    end
  end

  assign acc_out   = r_acc_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_ACC);

endmodule
